// File: rtl/ahb_lite_master_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_pkg : AHB-Lite encodings and width limits for the master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ahb_lite_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic       HRESP_OKAY      = 1'b0;
  localparam logic       HRESP_ERROR     = 1'b1;
  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF      = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  localparam int ADDR_MAX = 32;
  localparam int DATA_MAX = 32;

endpackage

`default_nettype wire

// File: rtl/ahb_lite_master_dphase.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_dphase : data-phase register and response capture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_lite_master_dphase
  import ahb_lite_master_pkg::*;
#(
  parameter int DATA = 32
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            hready,
  input  logic            hresp,
  input  logic [DATA-1:0] hrdata,
  input  logic            a_nonseq,
  input  logic            a_write,
  input  logic [DATA-1:0] a_wdata,
  output logic            dvalid,
  output logic [DATA-1:0] hwdata,
  output logic            rsp_valid,
  output logic            rsp_write,
  output logic            rsp_err,
  output logic [DATA-1:0] rsp_rdata
);

  logic            dvalid_q, dvalid_d;
  logic            dwrite_q, dwrite_d;
  logic [DATA-1:0] hwdata_q, hwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DATA-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    dvalid_d    = dvalid_q;
    dwrite_d    = dwrite_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (hready) begin
      // Completion and the hand-over of the next address phase share one edge
      if (dvalid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = dwrite_q;
        rsp_err_d   = (hresp == HRESP_ERROR);
        rsp_rdata_d = (!dwrite_q && hresp == HRESP_OKAY) ? hrdata : '0;
      end
      dvalid_d = a_nonseq;
      if (a_nonseq) begin
        dwrite_d = a_write;
        hwdata_d = a_wdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dvalid_q    <= 1'b0;
      dwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      dvalid_q    <= dvalid_d;
      dwrite_q    <= dwrite_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign dvalid    = dvalid_q;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master : valid/ready command stream to pipelined AHB-Lite singles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int DATA = 32
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic            cmd_write,
  input  logic [2:0]      cmd_size,
  input  logic [DATA-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic            rsp_write,
  output logic            rsp_err,
  output logic [DATA-1:0] rsp_rdata,
  output logic            busy,
  output logic [1:0]      htrans,
  output logic [2:0]      hburst,
  output logic [2:0]      hsize,
  output logic [3:0]      hprot,
  output logic            hmastlock,
  output logic [ADDR-1:0] haddr,
  output logic            hwrite,
  output logic [DATA-1:0] hwdata,
  input  logic [DATA-1:0] hrdata,
  input  logic            hresp,
  input  logic            hready
);

  htrans_e         htrans_q, htrans_d;
  logic [ADDR-1:0] haddr_q, haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hsize_q, hsize_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic            accept;
  logic            dvalid;
  logic            a_nonseq;

  assign cmd_ready = hready && !hreset;
  assign accept    = cmd_valid && cmd_ready;
  assign a_nonseq  = (htrans_q == HTRANS_NONSEQ);

  // Address stage only moves on hready; otherwise the bus is frozen
  always_comb begin
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    wdata_d  = wdata_q;
    if (hready) begin
      if (accept) begin
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = cmd_addr;
        hwrite_d = cmd_write;
        hsize_d  = cmd_size;
        wdata_d  = cmd_wdata;
      end else begin
        htrans_d = HTRANS_IDLE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      wdata_q  <= '0;
    end else begin
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      wdata_q  <= wdata_d;
    end
  end

  ahb_lite_master_dphase #(
    .DATA (DATA)
  ) u_dphase (
    .hclk      (hclk),
    .hreset    (hreset),
    .hready    (hready),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .a_nonseq  (a_nonseq),
    .a_write   (hwrite_q),
    .a_wdata   (wdata_q),
    .dvalid    (dvalid),
    .hwdata    (hwdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

  assign busy      = a_nonseq || dvalid || rsp_valid;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DATA_PRIV;
  assign hmastlock = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master : randomized scoreboard bench with an AHB responder model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ahb_lite_master;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [31:0] hrdata = '0;
  logic        hresp = 1'b0;
  logic        hready = 1'b1;

  ahb_lite_master #(.ADDR(32), .DATA(32)) dut (
    .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hprot(hprot),
    .hmastlock(hmastlock), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  always #5 hclk = ~hclk;

  typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; } aph_t;
  typedef struct { logic wr; logic err; logic [31:0] rdata; } rsp_t;

  aph_t        aphq[$];
  logic [31:0] wdq[$];
  rsp_t        rspq[$];

  int nvec = 0;
  int nerr = 0;

  // The responder answers ERROR for one address window and a fixed hash otherwise
  function automatic logic is_err(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge hclk) begin
    if (!hreset || rsp_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, rspq.size() > 0});
    end
    if (rsp_valid) begin
      if (rspq.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = rspq.pop_front();
        chk("rsp_write", {31'd0, rsp_write}, {31'd0, e.wr});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  logic        prev_hready, prev_rst;
  logic        ap_nonseq, ap_write, dp_active, dp_write;
  logic [31:0] ap_addr, dp_addr;
  int          err_stage;
  logic        pend_valid;
  aph_t        pend_aph;
  rsp_t        pend_rsp;
  logic [31:0] pend_wd;

  task automatic check_reset_state();
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
    chk("rst_hsize", {29'd0, hsize}, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  // One cycle of bench activity, run just after a rising edge
  task automatic step(input logic rst, input logic issue, input logic full);
    if (prev_rst) begin
      aphq.delete(); wdq.delete(); rspq.delete();
      dp_active = 1'b0; ap_nonseq = 1'b0; err_stage = 0;
      check_reset_state();
    end else begin
      if (pend_valid) begin
        aphq.push_back(pend_aph);
        rspq.push_back(pend_rsp);
        if (pend_aph.wr) wdq.push_back(pend_wd);
      end
      if (prev_hready) begin
        dp_active = ap_nonseq; dp_addr = ap_addr; dp_write = ap_write; err_stage = 0;
        if (dp_active && dp_write) begin
          if (wdq.size() == 0) chk("hwdata_unexpected", 32'd1, 32'd0);
          else chk("hwdata", hwdata, wdq.pop_front());
        end
        if (htrans == 2'b10) begin
          if (aphq.size() == 0) begin
            chk("nonseq_unexpected", 32'd1, 32'd0);
          end else begin
            aph_t a;
            a = aphq.pop_front();
            chk("haddr", haddr, a.addr);
            chk("hwrite", {31'd0, hwrite}, {31'd0, a.wr});
            chk("hsize", {29'd0, hsize}, {29'd0, a.size});
          end
        end else begin
          chk("htrans_idle", {30'd0, htrans}, 32'd0);
        end
      end
      ap_nonseq = (htrans == 2'b10); ap_addr = haddr; ap_write = hwrite;
    end
    if (prev_rst || rst) begin
      dp_active = 1'b0; ap_nonseq = 1'b0;
    end

    hreset = rst;
    hrdata = $urandom;
    if (dp_active && is_err(dp_addr)) begin
      hresp  = 1'b1;
      hready = (err_stage != 0);
      err_stage = 1;
    end else begin
      hready = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      hresp  = (!dp_active && hready) ? $urandom_range(0, 1) : 1'b0;
      if (dp_active && !dp_write && hready) hrdata = rd_val(dp_addr);
    end

    cmd_valid = issue && (full || $urandom_range(0, 9) < 7);
    cmd_addr  = $urandom & 32'h0000_0FFC;
    cmd_write = $urandom_range(0, 1);
    cmd_size  = 3'($urandom_range(0, 2));
    cmd_wdata = $urandom;
    pend_valid = cmd_valid && hready && !rst;
    pend_aph.addr = cmd_addr; pend_aph.wr = cmd_write; pend_aph.size = cmd_size;
    pend_wd = cmd_wdata;
    pend_rsp.wr    = cmd_write;
    pend_rsp.err   = is_err(cmd_addr);
    pend_rsp.rdata = (cmd_write || is_err(cmd_addr)) ? 32'd0 : rd_val(cmd_addr);

    #1;
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, hready && !rst});
    prev_hready = hready;
    prev_rst    = rst;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    int guard;
    prev_hready = 1'b1; prev_rst = 1'b1;
    ap_nonseq = 1'b0; ap_write = 1'b0; ap_addr = '0;
    dp_active = 1'b0; dp_write = 1'b0; dp_addr = '0;
    err_stage = 0; pend_valid = 1'b0;
    pend_aph = '{default: '0}; pend_rsp = '{default: '0}; pend_wd = '0;

    for (int i = 0; i < 3; i++) begin
      hreset = 1'b1; cmd_valid = 1'b1; hready = 1'b1;
      #1;
      chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("reset_htrans", {30'd0, htrans}, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      @(posedge hclk);
      #1;
    end
    chk("hburst", {29'd0, hburst}, 32'd0);
    chk("hprot", {28'd0, hprot}, 32'd3);
    chk("hmastlock", {31'd0, hmastlock}, 32'd0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      step(cyc == 700 || cyc == 1400 || cyc == 1401, 1'b1, cyc < 300);
    end

    guard = 0;
    while ((rspq.size() > 0 || pend_valid) && guard < 200) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("drain_timeout", {31'd0, guard >= 200}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
